// File: rtl/denise_pkg.sv
// denise_pkg: shared Denise register addresses, BPLCON3 fields and colour-table write command type.
package denise_pkg;
  localparam logic [7:0] REG_BPLCON3 = 8'h83;
  localparam logic [7:0] REG_COLOR_BASE = 8'hC0;
  localparam int BANK_MSB = 15;
  localparam int BANK_LSB = 13;
  localparam int LOCT_BIT = 9;
  typedef struct packed {
    logic [1:0] ena;
    logic [7:0] addr;
    logic [11:0] data;
  } colortable_wr_t;
endpackage

// File: rtl/denise_colortable_writer_if.sv
// denise_colortable_writer_if: custom register write bus in, colour table RAM write port out.
interface denise_colortable_writer_if;
  logic reg_wr;
  logic [7:0] reg_address_in;
  logic [15:0] data_in;
  logic [7:0] ram_wraddress;
  logic [11:0] ram_data;
  logic [1:0] ram_ena;
  logic ram_wren;
  modport master (output reg_wr, reg_address_in, data_in, input ram_wraddress, ram_data, ram_ena, ram_wren);
  modport slave (input reg_wr, reg_address_in, data_in, output ram_wraddress, ram_data, ram_ena, ram_wren);
endinterface

// File: rtl/denise_colortable_wr_fifo.sv
// denise_colortable_wr_fifo: synchronous FIFO of colour table write commands; push accepted when full if popping.
module denise_colortable_wr_fifo
  import denise_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic pop,
  input  colortable_wr_t din,
  output colortable_wr_t dout,
  output logic full,
  output logic empty
);
  localparam int AW = $clog2(DEPTH);
  colortable_wr_t mem [DEPTH];
  logic [AW:0] wp, rp;
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign dout = mem[rp[AW-1:0]];
  always_ff @(posedge clk)
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && (!full || pop)) begin
        mem[wp[AW-1:0]] <= din;
        wp <= wp + (AW+1)'(1);
      end
      if (pop && !empty) rp <= rp + (AW+1)'(1);
    end
endmodule

// File: rtl/denise_colortable_writer.sv
// denise_colortable_writer: decodes COLORxx/BPLCON3 writes into queued colour RAM writes.
// Define DENISE_COLORTABLE_CLEAR_EN for the post-reset sweep of the palette to CLEAR_VALUE.
module denise_colortable_writer
  import denise_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter logic [11:0] CLEAR_VALUE = 12'h000
) (
  input  logic clk,
  input  logic reset,
  input  logic clk7_en,
  input  logic aga,
  denise_colortable_writer_if.slave bus,
  output logic busy,
  output logic overflow
);
  logic [2:0] bank;
  logic loct, strobe, push, pop, full, empty, running;
  logic [7:0] clear_addr;
  logic unused;
  colortable_wr_t wr_in, wr_out;
  assign unused = bus.data_in[12];
  assign strobe = bus.reg_wr & clk7_en;
  assign push = strobe && bus.reg_address_in[7:5] == REG_COLOR_BASE[7:5];
  assign wr_in = '{ena: (aga && loct) ? 2'b01 : 2'b11,
                   addr: {aga ? bank : 3'd0, bus.reg_address_in[4:0]},
                   data: bus.data_in[11:0]};
  assign pop = running & ~empty;
  assign busy = ~running | ~empty | bus.ram_wren;
`ifdef DENISE_COLORTABLE_CLEAR_EN
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_RUN = 1'b1;
  logic [0:0] state;
  assign running = state == ST_RUN;
  always_ff @(posedge clk)
    if (reset) begin
      state <= ST_CLEAR;
      clear_addr <= '0;
    end else if (!running) begin
      clear_addr <= clear_addr + 8'd1;
      state <= clear_addr == 8'hFF ? ST_RUN : ST_CLEAR;
    end
`else
  assign running = 1'b1;
  assign clear_addr = '0;
`endif
  denise_colortable_wr_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk), .reset(reset), .push(push), .pop(pop),
    .din(wr_in), .dout(wr_out), .full(full), .empty(empty)
  );
  always_ff @(posedge clk)
    if (reset) begin
      bank <= '0;
      loct <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (strobe && bus.reg_address_in == REG_BPLCON3) begin
        bank <= bus.data_in[BANK_MSB:BANK_LSB];
        loct <= bus.data_in[LOCT_BIT];
      end
      if (push && full && !pop) overflow <= 1'b1;
    end
  // The sweep owns the RAM port; queued writes wait until RUN so they land after it.
  always_ff @(posedge clk)
    if (reset) begin
      bus.ram_wren <= 1'b0;
      bus.ram_ena <= '0;
      bus.ram_wraddress <= '0;
      bus.ram_data <= '0;
    end else if (!running) begin
      bus.ram_wren <= 1'b1;
      bus.ram_ena <= 2'b11;
      bus.ram_wraddress <= clear_addr;
      bus.ram_data <= CLEAR_VALUE;
    end else begin
      bus.ram_wren <= pop;
      if (pop) {bus.ram_ena, bus.ram_wraddress, bus.ram_data} <= wr_out;
    end
endmodule

// File: tb/tb_denise_colortable_writer.sv
// tb_denise_colortable_writer: queue-based palette write model plus directed literal checks.
module tb_denise_colortable_writer;
  import denise_pkg::*;
  localparam int DEPTH = 4;
  localparam logic [11:0] CV = 12'h000;
`ifdef DENISE_COLORTABLE_CLEAR_EN
  localparam int SWEEP0 = 0;
`else
  localparam int SWEEP0 = 256;
`endif
  logic clk = 1'b0, reset = 1'b1, clk7_en = 1'b0, aga = 1'b0, busy, overflow;
  int pass_cnt = 0, total_cnt = 0;
  denise_colortable_writer_if bus();
  denise_colortable_writer #(.FIFO_DEPTH(DEPTH), .CLEAR_VALUE(CV)) dut (
    .clk(clk), .reset(reset), .clk7_en(clk7_en), .aga(aga),
    .bus(bus), .busy(busy), .overflow(overflow)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask
  colortable_wr_t mq[$];
  int m_sweep;
  logic [2:0] m_bank;
  logic m_loct, m_ovf, m_wren, m_rst;
  logic m_valid = 1'b0;
  logic [7:0] m_addr;
  logic [11:0] m_data;
  logic [1:0] m_ena;
  // Model: sweep first, then drain queue; pop precedes push so a full queue accepts on a pop.
  initial forever begin
    @(posedge clk);
    m_valid = 1'b1;
    m_rst = reset;
    if (reset) begin
      mq.delete();
      m_sweep = SWEEP0;
      m_bank = 3'd0; m_loct = 1'b0; m_ovf = 1'b0;
      m_wren = 1'b0; m_addr = 8'd0; m_data = 12'd0; m_ena = 2'd0;
    end else begin
      m_wren = 1'b1;
      if (m_sweep < 256) begin
        m_addr = 8'(m_sweep); m_data = CV; m_ena = 2'b11; m_sweep++;
      end else if (mq.size() > 0) {m_ena, m_addr, m_data} = mq.pop_front();
      else m_wren = 1'b0;
      if (bus.reg_wr && clk7_en) begin
        if (bus.reg_address_in >= 8'hC0 && bus.reg_address_in <= 8'hDF) begin
          if (mq.size() < DEPTH)
            mq.push_back(colortable_wr_t'({(aga && m_loct) ? 2'b01 : 2'b11, aga ? m_bank : 3'd0,
                                           bus.reg_address_in[4:0], bus.data_in[11:0]}));
          else m_ovf = 1'b1;
        end
        if (bus.reg_address_in == 8'h83) begin
          m_bank = bus.data_in[15:13]; m_loct = bus.data_in[9];
        end
      end
    end
  end
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      check("m_wren", 32'(bus.ram_wren), 32'(m_wren));
      if (m_wren || m_rst) check("m_port", {10'd0, bus.ram_ena, bus.ram_wraddress, bus.ram_data},
                                 {10'd0, m_ena, m_addr, m_data});
      check("m_busy", 32'(busy), 32'(m_sweep < 256 || mq.size() > 0 || m_wren));
      check("m_ovf", 32'(overflow), 32'(m_ovf));
    end
  end
  task automatic wr(input logic [7:0] a, input logic [15:0] d);
    bus.reg_wr = 1'b1; clk7_en = 1'b1; bus.reg_address_in = a; bus.data_in = d;
    @(negedge clk);
    bus.reg_wr = 1'b0; clk7_en = 1'b0;
  endtask
  task automatic port_is(input string name, input logic [1:0] ena, input logic [7:0] a, input logic [11:0] d);
    @(negedge clk);
    check(name, {9'd0, bus.ram_wren, bus.ram_ena, bus.ram_wraddress, bus.ram_data}, {9'd0, 1'b1, ena, a, d});
  endtask
  task automatic wait_addr(input logic [7:0] a);
    int n = 0;
    while (!(bus.ram_wren && bus.ram_wraddress == a) && n < 400) begin
      @(negedge clk);
      n++;
    end
    check("wait_addr", 32'(n < 400), 32'd1);
  endtask
  task automatic pulse_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask
  initial begin
    bus.reg_wr = 1'b0; bus.reg_address_in = 8'd0; bus.data_in = 16'd0;
    repeat (3) @(negedge clk);
    check("rst_wren", 32'(bus.ram_wren), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    reset = 1'b0;
`ifdef DENISE_COLORTABLE_CLEAR_EN
    for (int i = 0; i < 256; i++) port_is("sweep", 2'b11, 8'(i), 12'h000);
`endif
    @(negedge clk);
    check("idle_wren", 32'(bus.ram_wren), 32'd0);
    check("idle_busy", 32'(busy), 32'd0);
    aga = 1'b0;
    wr(8'h83, 16'hE200);
    wr(8'hC5, 16'h0ABC);
    port_is("ecs", 2'b11, 8'h05, 12'hABC);
    bus.reg_wr = 1'b1; bus.reg_address_in = 8'hC6;
    @(negedge clk);
    bus.reg_wr = 1'b0;
    @(negedge clk);
    check("no_clk7", 32'(bus.ram_wren), 32'd0);
    aga = 1'b1;
    wr(8'h83, 16'hA200);
    wr(8'hDF, 16'h0123);
    port_is("aga_loct", 2'b01, 8'hBF, 12'h123);
    wr(8'h83, 16'hA000);
    wr(8'hDF, 16'h0456);
    port_is("aga_both", 2'b11, 8'hBF, 12'h456);
`ifdef DENISE_COLORTABLE_CLEAR_EN
    aga = 1'b0;
    pulse_reset();
    repeat (10) @(negedge clk);
    wr(8'hC1, 16'h0111);
    wr(8'hC2, 16'h0222);
    wr(8'hC3, 16'h0333);
    wait_addr(8'hFF);
    port_is("q1", 2'b11, 8'h01, 12'h111);
    port_is("q2", 2'b11, 8'h02, 12'h222);
    port_is("q3", 2'b11, 8'h03, 12'h333);
    @(negedge clk);
    check("q_end", 32'(bus.ram_wren), 32'd0);
    pulse_reset();
    repeat (5) @(negedge clk);
    for (int i = 0; i < DEPTH + 2; i++) wr(8'hC4 + 8'(i), 16'h0400 + 16'(i));
    check("ovf_set", 32'(overflow), 32'd1);
    wait_addr(8'hFF);
    for (int i = 0; i < DEPTH; i++) port_is("ovf_q", 2'b11, 8'h04 + 8'(i), 12'h400 + 12'(i));
    @(negedge clk);
    check("ovf_end", 32'(bus.ram_wren), 32'd0);
    check("ovf_sticky", 32'(overflow), 32'd1);
    pulse_reset();
    repeat (3) @(negedge clk);
    wr(8'hC1, 16'h0AAA);
    wr(8'hC2, 16'h0BBB);
    wait_addr(8'h40);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    port_is("restart", 2'b11, 8'h00, CV);
    check("restart_ovf", 32'(overflow), 32'd0);
    wait_addr(8'hFF);
    @(negedge clk);
    check("restart_end", 32'(bus.ram_wren), 32'd0);
    check("restart_busy", 32'(busy), 32'd0);
`endif
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
